// File: rtl/irq_pending_latch_pkg.sv
// Shared constants and types for the interrupt pending-latch front end.
// idx_onehot turns an acknowledge index into the one-hot retire vector.
package irq_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    localparam logic EDGE_MODE  = 1'b1;
    localparam logic LEVEL_MODE = 1'b0;

    typedef logic [N_REQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0] req_idx_t;

    function automatic req_vec_t idx_onehot(input logic en, input req_idx_t idx);
        req_vec_t v;
        v = '0;
        if (en) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/irq_pending_latch_if.sv
// Request/mask/acknowledge bundle between the interrupt source side and the latch.
// The latch is the slave; the consumer/stimulus side is the master.
interface irq_pending_latch_if;
    import irq_pkg::*;

    req_vec_t req_in;
    req_vec_t mask;
    logic     ack;
    req_idx_t ack_idx;
    logic     ovf_clr;
    req_vec_t pend_out;
    logic     irq;
    logic     overflow;

    modport master (
        output req_in, mask, ack, ack_idx, ovf_clr,
        input  pend_out, irq, overflow
    );

    modport slave (
        input  req_in, mask, ack, ack_idx, ovf_clr,
        output pend_out, irq, overflow
    );

endinterface

// File: rtl/irq_pending_latch_req_edge_detect.sv
// Holds the previous request sample and produces the per-line event vector:
// rising edges when EDGE=1, the raw level when EDGE=0.
module req_edge_detect #(
    parameter logic        EDGE  = 1'b1,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req_in,
    output logic [WIDTH-1:0] ev
);

    logic [WIDTH-1:0] req_q;

    // Reset to zero so a line held high across reset release reads as one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= '0;
        end else begin
            req_q <= req_in;
        end
    end

    always_comb begin
        ev = '0;
        if (EDGE) begin
            ev = req_in & ~req_q;
        end else begin
            ev = req_in;
        end
    end

endmodule

// File: rtl/irq_pending_latch.sv
// Sticky pending-request latch with mask gating and indexed acknowledge,
// feeding an 8-to-3 priority encoder downstream.
module irq_pending_latch
    import irq_pkg::*;
#(
    parameter logic EDGE = EDGE_MODE
) (
    input logic                clk,
    input logic                rst,
    irq_pending_latch_if.slave bus
);

    req_vec_t ev;
    req_vec_t clr;
    req_vec_t pending;
    logic     overflow_q;
    logic     ovf_set;

    req_edge_detect #(
        .EDGE  (EDGE),
        .WIDTH (N_REQ)
    ) u_edge (
        .clk    (clk),
        .rst    (rst),
        .req_in (bus.req_in),
        .ev     (ev)
    );

    always_comb begin
        clr     = idx_onehot(bus.ack, bus.ack_idx);
        ovf_set = |(ev & pending & ~clr);
    end

    // An event on a bit being retired this cycle re-arms it rather than overflowing.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending <= (pending & ~clr) | ev;
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.pend_out = pending & bus.mask;
        bus.irq      = |(pending & bus.mask);
        bus.overflow = overflow_q;
    end

endmodule

// File: tb/tb_irq_pending_latch.sv
// Bench for irq_pending_latch: edge- and level-mode instances driven with the same
// stimulus, a per-bit behavioural model, directed literal checks, then random traffic.
module tb_irq_pending_latch;
    import irq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] d_req  = '0;
    logic [7:0] d_mask = 8'hFF;
    logic       d_ack  = 1'b0;
    logic [2:0] d_idx  = '0;
    logic       d_oc   = 1'b0;

    irq_pending_latch_if ife ();
    irq_pending_latch_if ifl ();

    assign ife.req_in  = d_req;
    assign ife.mask    = d_mask;
    assign ife.ack     = d_ack;
    assign ife.ack_idx = d_idx;
    assign ife.ovf_clr = d_oc;
    assign ifl.req_in  = d_req;
    assign ifl.mask    = d_mask;
    assign ifl.ack     = d_ack;
    assign ifl.ack_idx = d_idx;
    assign ifl.ovf_clr = d_oc;

    irq_pending_latch #(.EDGE(EDGE_MODE)) dut_e (
        .clk (clk),
        .rst (rst),
        .bus (ife)
    );

    irq_pending_latch #(.EDGE(LEVEL_MODE)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (ifl)
    );

    int compared   = 0;
    int mismatched = 0;

    // Model: index 0 = edge instance, 1 = level instance.
    bit m_prev [2][8];
    bit m_pend [2][8];
    bit m_ovf  [2];
    bit started = 1'b0;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 8; i++) begin
                    m_prev[k][i] = 1'b0;
                    m_pend[k][i] = 1'b0;
                end
                m_ovf[k] = 1'b0;
            end else begin
                bit hit;
                hit = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    bit rose;
                    bit retire;
                    rose   = (k == 0) ? (d_req[i] && !m_prev[k][i]) : d_req[i];
                    retire = d_ack && (int'(d_idx) == i);
                    if (rose && m_pend[k][i] && !retire) hit = 1'b1;
                    if (rose) m_pend[k][i] = 1'b1;
                    else if (retire) m_pend[k][i] = 1'b0;
                    m_prev[k][i] = d_req[i];
                end
                if (hit) m_ovf[k] = 1'b1;
                else if (d_oc) m_ovf[k] = 1'b0;
            end
        end
        started = 1'b1;
    end

    function automatic logic [7:0] model_out(input int k);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i] = m_pend[k][i] & d_mask[i];
        return v;
    endfunction

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (started) begin
            logic [7:0] eo;
            logic [7:0] lo;
            eo = model_out(0);
            lo = model_out(1);
            cmp("e.pend_out", ife.pend_out, eo);
            cmp("e.irq", {7'b0, ife.irq}, {7'b0, |eo});
            cmp("e.overflow", {7'b0, ife.overflow}, {7'b0, m_ovf[0]});
            cmp("l.pend_out", ifl.pend_out, lo);
            cmp("l.irq", {7'b0, ifl.irq}, {7'b0, |lo});
            cmp("l.overflow", {7'b0, ifl.overflow}, {7'b0, m_ovf[1]});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset and edge capture
        rst = 1'b1; d_req = 8'h00; d_mask = 8'hFF;
        cyc();
        rst = 1'b0;
        cyc();
        cmp("rst.pend_out", ife.pend_out, 8'h00);
        cmp("rst.irq", {7'b0, ife.irq}, 8'h00);
        cmp("rst.overflow", {7'b0, ife.overflow}, 8'h00);
        d_req = 8'h80;
        cyc();
        cmp("edge.pend_out", ife.pend_out, 8'h80);
        cmp("edge.irq", {7'b0, ife.irq}, 8'h01);
        cyc();
        cyc();
        cmp("hold.pend_out", ife.pend_out, 8'h80);
        cmp("hold.overflow", {7'b0, ife.overflow}, 8'h00);

        // Ack retire, back-to-back
        d_ack = 1'b1; d_idx = 3'd7;
        cyc();
        d_ack = 1'b0; d_req = 8'h00;
        cyc();
        d_req = 8'h43;
        cyc();
        cmp("ack.setup", ife.pend_out, 8'h43);
        d_ack = 1'b1; d_idx = 3'd6;
        cyc();
        cmp("ack6.pend_out", ife.pend_out, 8'h03);
        d_idx = 3'd1;
        cyc();
        cmp("ack1.pend_out", ife.pend_out, 8'h01);
        d_idx = 3'd0;
        cyc();
        cmp("ack0.pend_out", ife.pend_out, 8'h00);
        cmp("ack0.irq", {7'b0, ife.irq}, 8'h00);
        d_ack = 1'b0;

        // Set-vs-clear collision
        d_req = 8'h00;
        cyc();
        d_req = 8'h08;
        cyc();
        d_req = 8'h00;
        cyc();
        d_req = 8'h08; d_ack = 1'b1; d_idx = 3'd3;
        cyc();
        cmp("coll.pend_out", ife.pend_out, 8'h08);
        cmp("coll.overflow", {7'b0, ife.overflow}, 8'h00);
        cyc();
        cmp("coll.retired", ife.pend_out, 8'h00);
        d_ack = 1'b0;

        // Overflow set and clear
        d_req = 8'h00;
        cyc();
        d_req = 8'h04;
        cyc();
        d_req = 8'h00;
        cyc();
        d_req = 8'h04;
        cyc();
        cmp("ovf.set", {7'b0, ife.overflow}, 8'h01);
        cmp("ovf.pend_out", ife.pend_out, 8'h04);
        d_oc = 1'b1;
        cyc();
        cmp("ovf.clr", {7'b0, ife.overflow}, 8'h00);
        d_oc = 1'b0; d_ack = 1'b1; d_idx = 3'd2;
        cyc();
        d_ack = 1'b0;

        // Masking holds pending bits; masked ack still retires
        d_req = 8'h00;
        cyc();
        d_req = 8'h2F;
        cyc();
        d_req = 8'h00; d_mask = 8'hF0;
        #1;
        cmp("mask.F0", ife.pend_out, 8'h20);
        d_mask = 8'hFF;
        #1;
        cmp("mask.FF", ife.pend_out, 8'h2F);
        d_mask = 8'hF0; d_ack = 1'b1; d_idx = 3'd0;
        cyc();
        d_ack = 1'b0; d_mask = 8'hFF;
        #1;
        cmp("mask.ack0", ife.pend_out, 8'h2E);
        d_ack = 1'b1;
        foreach (d_req[i]) begin
            if (i != 0) begin
                d_idx = 3'(i);
                cyc();
            end
        end
        d_ack = 1'b0;
        cmp("mask.drained", ife.pend_out, 8'h00);

        // Level mode and mid-operation reset
        rst = 1'b1;
        cyc();
        rst = 1'b0; d_req = 8'h18;
        cyc();
        cmp("lvl.pend_out", ifl.pend_out, 8'h18);
        cmp("lvl.ovf_first", {7'b0, ifl.overflow}, 8'h00);
        cyc();
        cmp("lvl.ovf_second", {7'b0, ifl.overflow}, 8'h01);
        rst = 1'b1;
        cyc();
        cmp("lvl.rst_pend", ifl.pend_out, 8'h00);
        cmp("lvl.rst_irq", {7'b0, ifl.irq}, 8'h00);
        cmp("lvl.rst_ovf", {7'b0, ifl.overflow}, 8'h00);
        cmp("edge.rst_pend", ife.pend_out, 8'h00);
        rst = 1'b0;
        cyc();
        cmp("lvl.release", ifl.pend_out, 8'h18);
        cmp("edge.held_release", ife.pend_out, 8'h18);

        // Random traffic checked by the per-cycle comparator
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(1) == 0) d_req = 8'($urandom) & 8'($urandom);
            d_mask = ($urandom_range(3) == 0) ? 8'($urandom) : 8'hFF;
            d_ack  = ($urandom_range(2) != 0);
            d_idx  = 3'($urandom);
            d_oc   = ($urandom_range(5) == 0);
            rst    = ($urandom_range(60) == 0);
            cyc();
        end
        rst = 1'b0;
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
